// File: rtl/prime_check_seq.sv
// Sequential prime tester: counts divisors 2..floor(n/2) of one candidate using
// bit-serial restoring division, one quotient bit per cycle.
module prime_check_seq #(
  parameter int unsigned WIDTH          = 8,
  parameter bit          ZERO_ONE_PRIME = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             out_prime,
  output logic [WIDTH-1:0] out_div_count,
  output logic             busy
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [SW-1:0]    step_q, step_d;
  logic             prime_q, prime_d;

  logic [WIDTH-1:0] half, in_half;
  logic [WIDTH:0]   t;
  logic             t_ge_j;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] cnt_inc;

  assign half    = n_q >> 1;
  assign in_half = in_num >> 1;

  // rem < j <= 2^(WIDTH-1), so the restored remainder always fits in WIDTH bits
  assign t       = {rem_q, n_q[step_q]};
  assign t_ge_j  = t >= {1'b0, j_q};
  assign rem_new = t_ge_j ? WIDTH'(t - {1'b0, j_q}) : t[WIDTH-1:0];
  assign cnt_inc = (rem_new == '0) ? cnt_q + WIDTH'(1) : cnt_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    step_d  = step_q;
    prime_d = prime_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          n_d    = in_num;
          j_d    = WIDTH'(2);
          cnt_d  = '0;
          rem_d  = '0;
          step_d = SW'(WIDTH - 1);
          if (in_half < WIDTH'(2)) begin
            // n <= 3: no trial divisors; only 0 and 1 need the special-case flag
            prime_d = (in_half == '0) ? ZERO_ONE_PRIME : 1'b1;
            state_d = StDone;
          end else begin
            prime_d = 1'b0;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (step_q == '0) begin
          cnt_d  = cnt_inc;
          j_d    = j_q + WIDTH'(1);
          rem_d  = '0;
          step_d = SW'(WIDTH - 1);
          if (j_q == half) begin
            prime_d = (cnt_inc == '0);
            state_d = StDone;
          end
        end else begin
          rem_d  = rem_new;
          step_d = step_q - SW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      prime_q <= prime_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StDone);
  assign busy          = (state_q != StIdle);
  assign out_num       = n_q;
  assign out_prime     = prime_q;
  assign out_div_count = cnt_q;

endmodule

// File: tb/tb_prime_check_seq.sv
// Directed bench for prime_check_seq: latency, results, backpressure, reset and a 0..200 sweep.
module tb_prime_check_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [W-1:0] in_num;
  logic         in_ready, out_valid, out_prime, busy;
  logic [W-1:0] out_num, out_div_count;

  logic         z_in_valid, z_out_ready;
  logic [W-1:0] z_in_num;
  logic         z_in_ready, z_out_valid, z_out_prime, z_busy;
  logic [W-1:0] z_out_num, z_out_div_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prime_check_seq #(.WIDTH(W), .ZERO_ONE_PRIME(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num), .out_prime(out_prime),
    .out_div_count(out_div_count), .busy(busy)
  );

  prime_check_seq #(.WIDTH(W), .ZERO_ONE_PRIME(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_num(z_in_num),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_num(z_out_num),
    .out_prime(z_out_prime), .out_div_count(z_out_div_count), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept n, wait for out_valid (at a negedge), check results; handshake if release=1.
  task automatic run(input string tag, input int n, input int lat_exp, input bit prime_exp,
                     input int cnt_exp, input bit release_out);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_num   = W'(n);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_num   = 8'hAA;
    lat = 1;
    while (!out_valid && lat < 1200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " num"}, 32'(out_num), 32'(n));
    check({tag, " prime"}, 32'(out_prime), 32'(prime_exp));
    check({tag, " count"}, 32'(out_div_count), 32'(cnt_exp));
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  function automatic int model_cnt(input int n);
    int c = 0;
    for (int j = 2; j <= n / 2; j++) if (n % j == 0) c++;
    return c;
  endfunction

  initial begin
    int s_num, s_prime, s_cnt, nprimes, lat, c;
    rst_n = 1'b0; in_valid = 1'b0; in_num = '0; out_ready = 1'b0;
    z_in_valid = 1'b0; z_in_num = '0; z_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_num", 32'(out_num), 32'd0);
    check("reset out_prime", 32'(out_prime), 32'd0);
    check("reset count", 32'(out_div_count), 32'd0);
    rst_n = 1'b1;

    run("prime7",    7,   17, 1'b1, 0, 1'b1);
    run("comp12",    12,  41, 1'b0, 4, 1'b1);
    run("small1",    1,   1,  1'b1, 0, 1'b1);
    run("small4",    4,   9,  1'b0, 1, 1'b1);
    run("max255",    255, 1009, 1'b0, 6, 1'b1);
    check("idle after handshake", 32'(busy), 32'd0);

    // ZERO_ONE_PRIME=0 instance with candidate 0
    @(negedge clk);
    z_in_valid = 1'b1; z_in_num = '0;
    @(posedge clk);
    @(negedge clk);
    z_in_valid = 1'b0;
    check("zop0 out_valid", 32'(z_out_valid), 32'd1);
    check("zop0 prime", 32'(z_out_prime), 32'd0);
    check("zop0 count", 32'(z_out_div_count), 32'd0);
    z_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_out_ready = 1'b0;
    check("zop0 idle", 32'(z_busy), 32'd0);

    // Backpressure on 13, then back-to-back candidate 2
    run("bp13", 13, 41, 1'b1, 0, 1'b0);
    in_valid = 1'b1; in_num = 8'd99;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp num", 32'(out_num), 32'd13);
      check("bp prime", 32'(out_prime), 32'd1);
      check("bp count", 32'(out_div_count), 32'd0);
    end
    out_ready = 1'b1; in_num = 8'd2;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b in_ready", 32'(in_ready), 32'd1);
    check("b2b out_valid low", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b num", 32'(out_num), 32'd2);
    check("b2b prime", 32'(out_prime), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during DIV of 200
    in_valid = 1'b1; in_num = 8'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst num", 32'(out_num), 32'd0);
    check("rst count", 32'(out_div_count), 32'd0);
    check("rst prime", 32'(out_prime), 32'd0);
    lat = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("rst no result", 32'(lat), 32'd0);

    // Sweep 0..200 against a trial-division model
    nprimes = 0;
    for (int n = 0; n <= 200; n++) begin
      c = model_cnt(n);
      s_cnt = c;
      s_prime = (n < 2) ? 1 : ((c == 0) ? 1 : 0);
      s_num = ((n / 2) >= 2) ? (n / 2 - 1) : 0;
      run("sweep", n, 1 + s_num * W, s_prime[0], s_cnt, 1'b0);
      if (out_prime) nprimes++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("sweep prime total", 32'(nprimes), 32'd48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prime_check_seq.md
# prime_check_seq

Sequential prime tester that accepts one unsigned candidate over a valid/ready handshake and returns its primality and divisor count over a second valid/ready handshake. It is the synthesizable stage that feeds the behavioural prime-listing and display stage. It replaces the unbounded `%` loop with bit-serial restoring division, one quotient bit per cycle, so latency is deterministic. A counter upstream of this block sweeps the candidates 0..200.

## Interface
- WIDTH, 8, candidate width in bits; also the width of the divisor, count and remainder datapaths
- ZERO_ONE_PRIME, 1, when 1, candidates 0 and 1 report prime, matching the existing listing output; when 0, they report non-prime
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  candidate present
- in_ready  out  1  block can accept a candidate
- in_num  in  WIDTH  candidate n, unsigned
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_num  out  WIDTH  candidate the result belongs to
- out_prime  out  1  1 = prime
- out_div_count  out  WIDTH  number of divisors j with 2 <= j <= floor(n/2) and n mod j == 0
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch n = in_num, set j=2, cnt=0, step=WIDTH-1, rem=0.
  - If floor(n/2) < 2 (n <= 3), go to DONE; otherwise go to DIV.
- DIV: one restoring-division step per cycle.
  - Form t = {rem, n[step]} in WIDTH+1 bits.
  - If t >= j, set rem = t - j; else rem = t.
  - Decrement step.
  - On the step==0 cycle, use the final remainder: if it is 0, cnt increments.
  - Then j increments, step reloads to WIDTH-1 and rem clears to 0.
  - If the old j == floor(n/2), go to DONE; otherwise remain in DIV.
- DONE:
  - out_valid=1. out_num, out_prime and out_div_count hold stable.
  - When out_ready is sampled high, go to IDLE.
- Primality:
  - For n >= 2: out_prime = (cnt == 0).
  - For n in {0, 1}: out_prime = ZERO_ONE_PRIME.
- Arithmetic:
  - floor(n/2) is n >> 1.
  - cnt <= floor(n/2), so it never overflows WIDTH.
  - j never exceeds 2^(WIDTH-1).
- in_ready=0 in DIV and DONE; candidates are never queued.

## Timing
- Reset (synchronous, rst_n low at a rising edge) gives:
  - State IDLE; in_ready=1.
  - out_valid=0, out_prime=0, out_num=0, out_div_count=0, busy=0.
  - Internal n, j, cnt, rem and step all 0.
- Reset mid-operation (DIV or DONE): the in-flight candidate is dropped and no result is produced.
- Cycle 0 is the cycle with in_valid && in_ready.
- Let D = max(0, floor(n/2) - 1). out_valid first rises in cycle L = 1 + D*WIDTH.
- DONE to IDLE takes one cycle: the earliest next accept is the cycle after out_valid && out_ready.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Backpressure: out_valid stays high and all out_* stay unchanged while out_ready=0, for any number of cycles.
- out_ready high outside DONE is ignored.
- in_valid high outside IDLE is ignored, and in_num is not sampled.

## Test plan
All scenarios use WIDTH=8 and ZERO_ONE_PRIME=1 unless stated.
- Prime 7: in_num=7, out_ready=1
  - -> out_valid in cycle 17 (D=2), out_prime=1, out_div_count=0, out_num=7.
- Composite 12: in_num=12
  - -> out_valid in cycle 41 (D=5), out_div_count=4 (divisors 2,3,4,6), out_prime=0.
- Small values: in_num=1 -> out_valid in cycle 1, out_prime=1, count 0.
  - in_num=4 -> cycle 9, count 1, prime 0.
  - Rerun with ZERO_ONE_PRIME=0: in_num=0 -> out_prime=0.
- Max candidate: in_num=255
  - -> cycle 1009, out_div_count=6 (3,5,15,17,51,85), out_prime=0.
- Backpressure and back-to-back: in_num=13 with out_ready held 0 for 5 cycles after out_valid.
  - -> outputs stable and in_ready=0 throughout.
  - Release out_ready: next candidate 2 is accepted exactly one cycle after the out handshake and returns prime=1 in cycle 1.
- Reset and sweep: drive rst_n low during DIV of in_num=200.
  - -> no out_valid, reset values on the next cycle.
  - Then sweep 0..200: the set of out_prime=1 results equals {0,1} plus the 46 primes up to 199.
